// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the multi-cycle shift unit.
// Optional carry output is enabled with SHIFT_SEQ_CARRY_EN.
package shift_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    // Same op encoding as the single-position datapath shifter
    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result bundle between the controller and shift_seq.
// The cout signal exists only when SHIFT_SEQ_CARRY_EN is defined.
interface shift_seq_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = shift_pkg::WIDTH,
    parameter int unsigned AMT_W = shift_pkg::AMT_W
) ();

    logic             start;
    logic [WIDTH-1:0] in;
    logic [1:0]       shift;
    logic [AMT_W-1:0] amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sout;
`ifdef SHIFT_SEQ_CARRY_EN
    logic             cout;
`endif

`ifdef SHIFT_SEQ_CARRY_EN
    modport master (output start, in, shift, amt, input busy, done, sout, cout);
    modport slave  (input start, in, shift, amt, output busy, done, sout, cout);
`else
    modport master (output start, in, shift, amt, input busy, done, sout);
    modport slave  (input start, in, shift, amt, output busy, done, sout);
`endif

endinterface

// File: rtl/shift_step.sv
// Combinational single-position shift step; the shifted-out bit port is
// present only when SHIFT_SEQ_CARRY_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = shift_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_op_e        op_i,
`ifdef SHIFT_SEQ_CARRY_EN
    output logic             out_bit_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    logic out_bit;

    always_comb begin
        data_o  = data_i;
        out_bit = 1'b0;
        unique case (op_i)
            SH_PASS: begin
                data_o  = data_i;
                out_bit = 1'b0;
            end
            SH_LSL: begin
                data_o  = {data_i[WIDTH-2:0], 1'b0};
                out_bit = data_i[WIDTH-1];
            end
            SH_LSR: begin
                data_o  = {1'b0, data_i[WIDTH-1:1]};
                out_bit = data_i[0];
            end
            SH_ASR: begin
                data_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                out_bit = data_i[0];
            end
            default: begin
                data_o  = data_i;
                out_bit = 1'b0;
            end
        endcase
    end

`ifdef SHIFT_SEQ_CARRY_EN
    assign out_bit_o = out_bit;
`else
    logic unused_out_bit;
    assign unused_out_bit = out_bit;
`endif

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle LSL/LSR/ASR unit: one bit position per clock, start/done handshake.
// Define SHIFT_SEQ_CARRY_EN to add the cout (last shifted-out bit) output.
module shift_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = shift_pkg::WIDTH,
    parameter int unsigned AMT_W = shift_pkg::AMT_W
) (
    input  logic      clk,
    input  logic      reset,
    shift_seq_if.slave bus
);

    state_e           state_q, state_d;
    shift_op_e        op_q, op_d;
    logic [WIDTH-1:0] sout_q, sout_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_data;
`ifdef SHIFT_SEQ_CARRY_EN
    logic             cout_q, cout_d;
    logic             step_bit;
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i    (sout_q),
        .op_i      (op_q),
`ifdef SHIFT_SEQ_CARRY_EN
        .out_bit_o (step_bit),
`endif
        .data_o    (step_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= SH_PASS;
            sout_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_SEQ_CARRY_EN
            cout_q  <= cout_d;
`endif
        end
    end

    // busy/done are registered decodes of the next state so they align with state_q
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
`ifdef SHIFT_SEQ_CARRY_EN
        cout_d  = cout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sout_d = bus.in;
                    op_d   = shift_op_e'(bus.shift);
                    cnt_d  = bus.amt;
`ifdef SHIFT_SEQ_CARRY_EN
                    cout_d = 1'b0;
`endif
                    if ((bus.amt != '0) && (bus.shift != SH_PASS)) state_d = SHIFT;
                    else                                           state_d = FIN;
                end
            end
            SHIFT: begin
                sout_d = step_data;
                cnt_d  = cnt_q - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
                cout_d = step_bit;
`endif
                if (cnt_q == AMT_W'(1)) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == FIN);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sout = sout_q;
`ifdef SHIFT_SEQ_CARRY_EN
    assign bus.cout = cout_q;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver queues expected results, a monitor checks on done.
// Also checks cout when built with SHIFT_SEQ_CARRY_EN.
module tb_shift_seq;
    import shift_pkg::*;

    typedef struct {
        logic [15:0] sout;
        logic        cout;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_seq_if bus ();

    shift_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_sout"}, 32'(bus.sout), 32'(e.sout));
                check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
`ifdef SHIFT_SEQ_CARRY_EN
                check({e.name, "_cout"}, 32'(bus.cout), 32'(e.cout));
`endif
            end
        end
    end

    task automatic run_op(input string name, input logic [15:0] din, input logic [1:0] sh,
                          input logic [3:0] amt, input logic [15:0] exp_sout, input logic exp_cout);
        bit   pass;
        int   lat;
        bit   saw_busy;
        int   waited;
        exp_t e;
        pass     = (amt == 4'd0) || (sh == 2'b00);
        lat      = pass ? 1 : int'(amt) + 1;
        saw_busy = 1'b0;
        waited   = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.in = din; bus.shift = sh; bus.amt = amt;
        @(posedge clk); #1;
        // Scramble operands after acceptance; the captured copy must be used
        bus.start = 1'b0; bus.in = ~din; bus.shift = ~sh; bus.amt = ~amt;
        e.sout = exp_sout; e.cout = exp_cout; e.cyc = cyc + lat - 1; e.name = name;
        exp_q.push_back(e);
        while (exp_q.size() != 0 && waited < 40) begin
            if (bus.busy === 1'b1) saw_busy = 1'b1;
            @(posedge clk); #2;
            waited++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({name, "_busy_seen"}, 32'(saw_busy), pass ? 32'd0 : 32'd1);
        check({name, "_done_dropped"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        reset = 1'b1;
        bus.start = 1'b0; bus.in = '0; bus.shift = '0; bus.amt = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sout", 32'(bus.sout), 32'd0);
        reset = 1'b0;

        // Reset mid-operation aborts without a done
        @(posedge clk); #1;
        bus.start = 1'b1; bus.in = 16'hFFFF; bus.shift = 2'b01; bus.amt = 4'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #2;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sout", 32'(bus.sout), 32'd0);
`ifdef SHIFT_SEQ_CARRY_EN
        check("abort_cout", 32'(bus.cout), 32'd0);
`endif
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        run_op("lsl15",   16'h0001, 2'b01, 4'd15, 16'h8000, 1'b0);
        run_op("asr15",   16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0);
        run_op("lsr4",    16'hB00F, 2'b10, 4'd4,  16'h0B00, 1'b1);
        run_op("amt0",    16'h1234, 2'b01, 4'd0,  16'h1234, 1'b0);
        run_op("pass7",   16'h1234, 2'b00, 4'd7,  16'h1234, 1'b0);
        run_op("lsr15",   16'h8001, 2'b10, 4'd15, 16'h0001, 1'b0);
        run_op("asr4",    16'h8008, 2'b11, 4'd4,  16'hF800, 1'b1);
        run_op("asr3pos", 16'h7FF0, 2'b11, 4'd3,  16'h0FFE, 1'b0);
        run_op("lsl1",    16'h80F0, 2'b01, 4'd1,  16'h01E0, 1'b1);

        // start pulses during SHIFT and during FIN are ignored
        begin
            exp_t e;
            @(posedge clk); #1;
            bus.start = 1'b1; bus.in = 16'h00F0; bus.shift = 2'b10; bus.amt = 4'd4;
            @(posedge clk); #1;
            e.sout = 16'h000F; e.cout = 1'b0; e.cyc = cyc + 4; e.name = "ignore";
            exp_q.push_back(e);
            bus.in = 16'hFFFF; bus.amt = 4'd1; bus.shift = 2'b01;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(posedge clk); #1;
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("ignore_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            check("ignore_fin_busy", 32'(bus.busy), 32'd0);
            check("ignore_fin_done", 32'(bus.done), 32'd0);
            check("ignore_sout_hold", 32'(bus.sout), 32'h000F);
            repeat (3) @(posedge clk);
        end
        run_op("after_ignore", 16'h00F0, 2'b01, 4'd1, 16'h01E0, 1'b0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
